divf_seq: RTL and testbench

DIVF_SEQ -- requirements
Module: divf_seq

---
 rtl/divf_seq_if.sv | 12 +
 rtl/divf_seq.sv | 113 +++++++++++
 tb/tb_divf_seq.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/divf_seq_if.sv
// Request/result bundle for the sequential single-precision divider.
interface divf_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] s;
  logic        busy;
  logic        done;

  modport master (output start, a, b, input s, busy, done);
  modport slave  (input start, a, b, output s, busy, done);
endinterface

// File: rtl/divf_seq.sv
// Sequential IEEE-754 single-precision divider: restoring mantissa division,
// one quotient bit per cycle, truncating, fixed 26-edge latency.
module divf_seq (
  input  logic       clk,
  input  logic       rst_n,
  divf_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_NORM, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [23:0]        r_rem;
  logic [24:0]        r_q;
  logic [4:0]         r_cnt;
  logic [31:0]        r_s;

  logic               w_accept;
  logic [23:0]        w_ma;
  logic [23:0]        w_mb;
  logic [24:0]        w_trial;
  logic               w_bit;
  logic [23:0]        w_sub;
  logic [23:0]        w_rem_nxt;
  logic signed [9:0]  w_exp_raw;
  logic signed [9:0]  w_exp_norm;
  logic [22:0]        w_mant;
  logic [31:0]        w_result;

  // Special-case override and final packing; the first match wins.
  function automatic logic [31:0] pack_result(
    input logic              sgn,
    input logic              a_zero,
    input logic              b_zero,
    input logic signed [9:0] exp_n,
    input logic [22:0]       mant
  );
    if (b_zero)                  return {sgn, 8'hFF, 23'h0};
    else if (a_zero)             return {sgn, 31'h0};
    else if (exp_n >= 10'sd255)  return {sgn, 8'hFF, 23'h0};
    else if (exp_n <= 10'sd0)    return {sgn, 31'h0};
    else                         return {sgn, exp_n[7:0], mant};
  endfunction

  assign w_accept = (r_state == S_IDLE) && bus.start;

  // Restoring step: the first CALC cycle compares the raw dividend mantissa,
  // later cycles compare the doubled partial remainder.
  assign w_ma      = {1'b1, r_a[22:0]};
  assign w_mb      = {1'b1, r_b[22:0]};
  assign w_trial   = (r_cnt == 5'd24) ? {1'b0, w_ma} : {r_rem, 1'b0};
  assign w_bit     = (w_trial >= {1'b0, w_mb});
  assign w_sub     = w_trial[23:0] - w_mb;
  assign w_rem_nxt = w_bit ? w_sub : w_trial[23:0];

  // Quotient lies in [2^23, 2^25): bit 24 decides the one-place normalisation.
  assign w_exp_raw  = $signed({2'b00, r_a[30:23]}) - $signed({2'b00, r_b[30:23]}) + 10'sd127;
  assign w_exp_norm = r_q[24] ? w_exp_raw : (w_exp_raw - 10'sd1);
  assign w_mant     = r_q[24] ? r_q[23:1] : r_q[22:0];
  assign w_result   = pack_result(r_a[31] ^ r_b[31], (r_a[30:23] == 8'h00),
                                  (r_b[30:23] == 8'h00), w_exp_norm, w_mant);

  // Next-state logic for IDLE -> CALC -> NORM -> DONE -> IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_next = S_CALC;
      S_CALC:  if (r_cnt == 5'd0) w_next = S_NORM;
      S_NORM:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State, iteration counter, remainder/quotient and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_rem   <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_s     <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_rem <= '0;
        r_q   <= '0;
        r_cnt <= 5'd24;
      end else if (r_state == S_CALC) begin
        r_rem <= w_rem_nxt;
        r_q   <= {r_q[23:0], w_bit};
        if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
      end else if (r_state == S_NORM) begin
        r_s <= w_result;
      end
    end
  end

  // Operand capture at the start-accept edge; pure data, no reset needed.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= bus.a;
      r_b <= bus.b;
    end
  end

  assign bus.s    = r_s;
  assign bus.busy = (r_state != S_IDLE);
  assign bus.done = (r_state == S_DONE);

endmodule

// File: tb/tb_divf_seq.sv
// Scoreboard bench for divf_seq: stimulus pushes expected results, a monitor
// pops and compares on every done pulse, including latency and busy length.
module tb_divf_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divf_seq_if ifc ();
  divf_seq dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] s;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_pass    = 0;
  int   n_total   = 0;
  bit   abort_run = 1'b0;
  int   busy_run  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h (cycle %0d)", name, act, req, cyc);
  endtask

  // Reference: plain integer long division of the 24-bit mantissas.
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic        sg;
    longint      ma, mb, q;
    int          e;
    logic [22:0] m;
    sg = a[31] ^ b[31];
    if (b[30:23] == 8'h00) return {sg, 8'hFF, 23'h0};
    if (a[30:23] == 8'h00) return {sg, 31'h0};
    ma = longint'({1'b1, a[22:0]});
    mb = longint'({1'b1, b[22:0]});
    q  = (ma <<< 24) / mb;
    e  = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q >= (longint'(1) <<< 24)) m = 23'((q >>> 1) & 64'h7FFFFF);
    else begin
      m = 23'(q & 64'h7FFFFF);
      e = e - 1;
    end
    if (e >= 255) return {sg, 8'hFF, 23'h0};
    if (e <= 0)   return {sg, 31'h0};
    return {sg, 8'(e), m};
  endfunction

  // Issue one operation once the divider is idle; returns the accept cycle.
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb_, input logic [31:0] req,
                       output int acc);
    exp_t e;
    @(negedge clk);
    for (int k = 0; k < 100 && ifc.busy; k++) @(negedge clk);
    if (ifc.busy) begin
      n_total++;
      $display("FAIL idle_wait: busy still 1 after 100 cycles, required 0");
    end
    ifc.a     = ta;
    ifc.b     = tb_;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    acc   = cyc;
    e.s   = req;
    e.acc = acc;
    sb.push_back(e);
  endtask

  // Monitor: result/latency on done, busy-window length on busy fall.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && ifc.done) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 required done=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("result", ifc.s, e.s);
        chk("latency", 32'(cyc - e.acc), 32'd26);
      end
    end
    if (ifc.busy) busy_run++;
    else begin
      if (busy_run > 0 && !abort_run) chk("busy_len", 32'(busy_run), 32'd27);
      busy_run  = 0;
      abort_run = 1'b0;
    end
  end

  initial begin
    int          acc;
    logic [31:0] ra, rb;
    ifc.start = 1'b0;
    ifc.a     = '0;
    ifc.b     = '0;

    repeat (3) @(negedge clk);
    chk("reset_s", ifc.s, 32'h0);
    chk("reset_busy", {31'h0, ifc.busy}, 32'h0);
    chk("reset_done", {31'h0, ifc.done}, 32'h0);
    rst_n = 1'b1;

    // Directed cases with hand-derived results.
    issue(32'h40C00000, 32'h40000000, 32'h40400000, acc);
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, acc);
    issue(32'hBF800000, 32'h00000000, 32'hFF800000, acc);
    issue(32'h00000000, 32'hC0000000, 32'h80000000, acc);
    issue(32'h7F000000, 32'h00800001, 32'h7F800000, acc);
    issue(32'h00800000, 32'h7F000000, 32'h00000000, acc);

    // Start pulses at edges 5 and 20 of a running operation must be ignored.
    issue(32'h40C00000, 32'h40000000, 32'h40400000, acc);
    repeat (4) @(posedge clk);
    #1;
    ifc.a = 32'h3F800000; ifc.b = 32'h40400000; ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    ifc.start = 1'b1;
    @(posedge clk);
    #1;
    ifc.start = 1'b0;

    // Reset at edge 10 of an operation aborts it with no later done.
    issue(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, acc);
    repeat (10) @(posedge clk);
    #1;
    abort_run = 1'b1;
    rst_n     = 1'b0;
    sb.delete();
    #1;
    chk("abort_s", ifc.s, 32'h0);
    chk("abort_busy", {31'h0, ifc.busy}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    issue(32'h40400000, 32'h40000000, 32'h3FC00000, acc);

    // Randomised operands, issued back to back, against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 7) == 0) ra[30:23] = 8'h00;
      if ($urandom_range(0, 7) == 0) rb[30:23] = 8'h00;
      if ($urandom_range(0, 5) == 0) begin
        ra[30:23] = 8'($urandom_range(200, 255));
        rb[30:23] = 8'($urandom_range(1, 60));
      end
      if ($urandom_range(0, 5) == 0) begin
        ra[30:23] = 8'($urandom_range(1, 60));
        rb[30:23] = 8'($urandom_range(190, 255));
      end
      issue(ra, rb, ref_div(ra, rb), acc);
    end

    for (int k = 0; k < 200 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: %0d results outstanding, required 0", sb.size());
    end
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
